v_chunk_fifo: RTL and testbench

Chunk-granular first-word-fall-through FIFO that sits directly upstream of the vector shift stage in the mlops pipeline. Buffers WorkingRegs-wide chunks of signed NBits elements from the producer. Presents the head chunk plus a not-empty flag that drive the shift stage's data and data-ready inputs, and pops on its chunk-request output. Tags each chunk with an end-of-vector marker so downstream stages can track vector boundaries without their own counters.

---
 rtl/v_chunk_fifo_pkg.sv | 13 +
 rtl/v_chunk_fifo_if.sv | 33 +++
 rtl/v_chunk_fifo.sv | 93 +++++++++
 tb/tb_v_chunk_fifo.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/v_chunk_fifo_pkg.sv
// Shared mlops definitions: element and chunk defaults plus sizing helpers.
package v_chunk_fifo_pkg;

  localparam int unsigned NBitsDefault       = 8;
  localparam int unsigned WorkingRegsDefault = 4;

  typedef logic signed [WorkingRegsDefault-1:0][NBitsDefault-1:0] chunk_t;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/v_chunk_fifo_if.sv
// Producer/consumer handshake bundle of the chunk FIFO.
interface v_chunk_fifo_if #(
  parameter int unsigned NBits       = 8,
  parameter int unsigned WorkingRegs = 4,
  parameter int unsigned Depth       = 8
);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic                                   flush_in;
  logic                                   wr_valid_in;
  logic signed [WorkingRegs-1:0][NBits-1:0] wr_data_in;
  logic                                   wr_ready_out;
  logic                                   rd_req_in;
  logic signed [WorkingRegs-1:0][NBits-1:0] rd_data_out;
  logic                                   rd_ready_out;
  logic                                   rd_last_out;
  logic [CntW-1:0]                        count_out;
  logic                                   overflow_out;
  logic                                   underflow_out;

  modport master (
    output flush_in, wr_valid_in, wr_data_in, rd_req_in,
    input  wr_ready_out, rd_data_out, rd_ready_out, rd_last_out, count_out,
           overflow_out, underflow_out
  );

  modport slave (
    input  flush_in, wr_valid_in, wr_data_in, rd_req_in,
    output wr_ready_out, rd_data_out, rd_ready_out, rd_last_out, count_out,
           overflow_out, underflow_out
  );

endinterface

// File: rtl/v_chunk_fifo.sv
// First-word-fall-through chunk FIFO with end-of-vector tagging and sticky
// overflow/underflow flags.
module v_chunk_fifo
  import v_chunk_fifo_pkg::*;
#(
  parameter int unsigned NBits       = NBitsDefault,
  parameter int unsigned WorkingRegs = WorkingRegsDefault,
  parameter int unsigned InVecLength = 16,
  parameter int unsigned Depth       = 8
) (
  input logic           clk_in,
  input logic           rst_in,
  v_chunk_fifo_if.slave bus
);

  localparam int unsigned ChunksPerVec = ceil_div(InVecLength, WorkingRegs);
  localparam int unsigned WcW          = (ChunksPerVec > 1) ? $clog2(ChunksPerVec) : 1;
  localparam int unsigned PtrW         = $clog2(Depth);
  localparam int unsigned CntW         = PtrW + 1;

  typedef logic signed [WorkingRegs-1:0][NBits-1:0] chunk_w_t;

  chunk_w_t        r_mem_data [Depth];
  logic            r_mem_last [Depth];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic [WcW-1:0]  r_wc;
  logic            r_overflow;
  logic            r_underflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_wc_last;

  assign w_full    = (r_count == CntW'(Depth));
  assign w_empty   = (r_count == '0);
  // Accept decisions use start-of-cycle occupancy only; no pass-through or bypass.
  assign w_push    = bus.wr_valid_in && !w_full && !bus.flush_in;
  assign w_pop     = bus.rd_req_in && !w_empty && !bus.flush_in;
  assign w_wc_last = (r_wc == WcW'(ChunksPerVec - 1));

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= bus.wr_data_in;
      r_mem_last[r_wr_ptr] <= w_wc_last;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wc        <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.flush_in) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wc        <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
        r_wc     <= w_wc_last ? '0 : r_wc + WcW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
      if (bus.wr_valid_in && w_full) r_overflow <= 1'b1;
      if (bus.rd_req_in && w_empty) r_underflow <= 1'b1;
    end
  end

  assign bus.wr_ready_out  = !w_full;
  assign bus.rd_ready_out  = !w_empty;
  assign bus.rd_data_out   = w_empty ? '0 : r_mem_data[r_rd_ptr];
  assign bus.rd_last_out   = w_empty ? 1'b0 : r_mem_last[r_rd_ptr];
  assign bus.count_out     = r_count;
  assign bus.overflow_out  = r_overflow;
  assign bus.underflow_out = r_underflow;

endmodule

// File: tb/tb_v_chunk_fifo.sv
// Scenario bench for v_chunk_fifo: queue-based reference, one task per scenario.
module tb_v_chunk_fifo;

  localparam int unsigned NB    = 8;
  localparam int unsigned WR    = 4;
  localparam int unsigned VL    = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CPV   = (VL + WR - 1) / WR;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  typedef logic signed [WR-1:0][NB-1:0] chunk_t;
  typedef struct packed {
    logic   last;
    chunk_t data;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  v_chunk_fifo_if #(.NBits(NB), .WorkingRegs(WR), .Depth(DEPTH)) bus ();

  v_chunk_fifo #(
    .NBits(NB), .WorkingRegs(WR), .InVecLength(VL), .Depth(DEPTH)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  exp_t sb[$];
  int   m_wc;
  logic m_ovf;
  logic m_unf;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic chunk_t mk(input int a, input int b, input int c, input int d);
    chunk_t r;
    r[0] = a[NB-1:0];
    r[1] = b[NB-1:0];
    r[2] = c[NB-1:0];
    r[3] = d[NB-1:0];
    return r;
  endfunction

  task automatic model_clear();
    sb.delete();
    m_wc  = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // One clock with the given request; the reference updates from pre-edge occupancy.
  task automatic step(input logic wv, input logic rr, input chunk_t d);
    bit full;
    bit empty;
    exp_t e;
    bus.wr_valid_in = wv;
    bus.rd_req_in   = rr;
    bus.wr_data_in  = d;
    full  = (sb.size() == DEPTH);
    empty = (sb.size() == 0);
    if (wv && full) m_ovf = 1'b1;
    if (rr && empty) m_unf = 1'b1;
    if (rr && !empty) void'(sb.pop_front());
    if (wv && !full) begin
      e.data = d;
      e.last = (m_wc == CPV - 1);
      sb.push_back(e);
      m_wc = (m_wc == CPV - 1) ? 0 : m_wc + 1;
    end
    @(posedge clk_in);
    #1;
    bus.wr_valid_in = 1'b0;
    bus.rd_req_in   = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush_in = 1'b1;
    @(posedge clk_in);
    #1;
    bus.flush_in = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    #3;
    if (bus.count_out !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count_out); end
    n_vec++;
    if ({bus.wr_ready_out, bus.rd_ready_out, bus.rd_last_out} !== 3'b100) begin
      n_err++; $display("FAIL reset_ready: got %b want 100", {bus.wr_ready_out, bus.rd_ready_out, bus.rd_last_out});
    end
    n_vec++;
    if (bus.rd_data_out !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", bus.rd_data_out); end
    n_vec++;
    if ({bus.overflow_out, bus.underflow_out} !== 2'b00) begin
      n_err++; $display("FAIL reset_flags: got %b want 00", {bus.overflow_out, bus.underflow_out});
    end
    n_vec++;
    #8 rst_in = 1'b1;
    model_clear();
  endtask

  task automatic test_push3();
    step(1'b1, 1'b0, mk(1, 2, 3, 4));
    step(1'b1, 1'b0, mk(5, 6, 7, 8));
    step(1'b1, 1'b0, mk(9, 10, 11, 12));
    if (bus.count_out !== CW'(3)) begin n_err++; $display("FAIL push3_count: got %0d want 3", bus.count_out); end
    n_vec++;
    if (bus.rd_data_out !== mk(1, 2, 3, 4)) begin n_err++; $display("FAIL push3_head: got %h want %h", bus.rd_data_out, mk(1, 2, 3, 4)); end
    n_vec++;
    if ({bus.rd_last_out, bus.overflow_out, bus.underflow_out} !== 3'b000) begin
      n_err++; $display("FAIL push3_flags: got %b want 000", {bus.rd_last_out, bus.overflow_out, bus.underflow_out});
    end
    n_vec++;
    do_flush();
  endtask

  task automatic test_tags();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, mk(i, i + 16, -i, 7));
    for (int i = 0; i < 8; i++) begin
      if (bus.rd_data_out !== sb[0].data) begin n_err++; $display("FAIL tags_head%0d: got %h want %h", i, bus.rd_data_out, sb[0].data); end
      n_vec++;
      if (bus.rd_last_out !== ((i % 4) == 3)) begin n_err++; $display("FAIL tags_last%0d: got %b want %b", i, bus.rd_last_out, (i % 4) == 3); end
      n_vec++;
      step(1'b0, 1'b1, '0);
    end
    if (bus.count_out !== '0) begin n_err++; $display("FAIL tags_count: got %0d want 0", bus.count_out); end
    n_vec++;
    if ({bus.rd_data_out, bus.rd_ready_out, bus.rd_last_out} !== '0) begin
      n_err++; $display("FAIL tags_empty: got %h/%b/%b want 0", bus.rd_data_out, bus.rd_ready_out, bus.rd_last_out);
    end
    n_vec++;
    do_flush();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, mk(i + 40, i, i, i));
    if ({bus.count_out, bus.wr_ready_out} !== {CW'(DEPTH), 1'b0}) begin
      n_err++; $display("FAIL full_state: got %0d/%b want %0d/0", bus.count_out, bus.wr_ready_out, DEPTH);
    end
    n_vec++;
    step(1'b1, 1'b1, mk(99, 99, 99, 99));
    if (bus.overflow_out !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", bus.overflow_out); end
    n_vec++;
    if (bus.count_out !== CW'(DEPTH - 1)) begin n_err++; $display("FAIL ovf_count: got %0d want %0d", bus.count_out, DEPTH - 1); end
    n_vec++;
    if (bus.rd_data_out !== mk(41, 1, 1, 1)) begin n_err++; $display("FAIL ovf_head: got %h want %h", bus.rd_data_out, mk(41, 1, 1, 1)); end
    n_vec++;
    do_flush();
  endtask

  task automatic test_underflow();
    step(1'b1, 1'b1, mk(-1, -2, -3, -4));
    if (bus.underflow_out !== 1'b1) begin n_err++; $display("FAIL unf_flag: got %b want 1", bus.underflow_out); end
    n_vec++;
    if (bus.count_out !== CW'(1)) begin n_err++; $display("FAIL unf_count: got %0d want 1", bus.count_out); end
    n_vec++;
    if (bus.rd_data_out !== mk(-1, -2, -3, -4)) begin n_err++; $display("FAIL unf_data: got %h want %h", bus.rd_data_out, mk(-1, -2, -3, -4)); end
    n_vec++;
    do_flush();
  endtask

  task automatic test_back_to_back();
    logic wv;
    logic rr;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, chunk_t'($urandom));
    for (int i = 0; i < 20; i++) begin
      wv = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      if (sb.size() >= 5) begin rr = 1'b1; wv = (i % 3) != 0; end
      if (sb.size() <= 3) begin wv = 1'b1; rr = (i % 2) != 0; end
      step(wv, rr, chunk_t'($urandom));
      if (bus.count_out !== CW'(sb.size())) begin n_err++; $display("FAIL rnd_count%0d: got %0d want %0d", i, bus.count_out, sb.size()); end
      n_vec++;
      if ({bus.rd_last_out, bus.rd_data_out} !== {sb[0].last, sb[0].data}) begin
        n_err++; $display("FAIL rnd_head%0d: got %b/%h want %b/%h", i, bus.rd_last_out, bus.rd_data_out, sb[0].last, sb[0].data);
      end
      n_vec++;
    end
    if ({bus.overflow_out, bus.underflow_out} !== 2'b00) begin
      n_err++; $display("FAIL rnd_flags: got %b want 00", {bus.overflow_out, bus.underflow_out});
    end
    n_vec++;
    do_flush();
  endtask

  task automatic test_reset_flush();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, mk(i, 1, 2, 3));
    #2 rst_in = 1'b0;
    #1;
    if ({bus.count_out, bus.wr_ready_out, bus.rd_ready_out, bus.rd_last_out} !== {CW'(0), 3'b100}) begin
      n_err++; $display("FAIL async_rst_ctrl: got %0d/%b%b%b want 0/100", bus.count_out, bus.wr_ready_out, bus.rd_ready_out, bus.rd_last_out);
    end
    n_vec++;
    if ({bus.rd_data_out, bus.overflow_out, bus.underflow_out} !== '0) begin
      n_err++; $display("FAIL async_rst_data: got %h/%b%b want 0/00", bus.rd_data_out, bus.overflow_out, bus.underflow_out);
    end
    n_vec++;
    #3 rst_in = 1'b1;
    model_clear();
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b0, mk(7, 7, 7, 7));
    step(1'b1, 1'b0, mk(8, 8, 8, 8));
    if ({bus.count_out, bus.underflow_out} !== {CW'(2), 1'b1}) begin
      n_err++; $display("FAIL preflush: got %0d/%b want 2/1", bus.count_out, bus.underflow_out);
    end
    n_vec++;
    do_flush();
    if ({bus.count_out, bus.rd_ready_out, bus.overflow_out, bus.underflow_out} !== {CW'(0), 3'b000}) begin
      n_err++; $display("FAIL flush_state: got %0d/%b%b%b want 0/000", bus.count_out, bus.rd_ready_out, bus.overflow_out, bus.underflow_out);
    end
    n_vec++;
  endtask

  initial begin
    bus.flush_in    = 1'b0;
    bus.wr_valid_in = 1'b0;
    bus.rd_req_in   = 1'b0;
    bus.wr_data_in  = '0;
    #1;
    test_reset();
    test_push3();
    test_tags();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
